// File: rtl/riscv_irq_pkg.sv
// Shared constants and types for the interrupt controller.
// Register offsets are byte offsets within the device window.
package riscv_irq_pkg;

    localparam int MAX_SRC = 16;

    localparam logic [23:0] IRQ_MASK_OFF = 24'h00_0000;
    localparam logic [23:0] IRQ_PEND_OFF = 24'h00_0004;
    localparam logic [23:0] IRQ_CUR_OFF  = 24'h00_0008;
    localparam logic [23:0] IRQ_CTRL_OFF = 24'h00_000C;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RET
    } irq_state_t;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of vec (bit 0 wins).
// Latency: combinational; backpressure: none.
module riscv_irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [3:0]       id
);

    // Scan downward so the last hit, which is the lowest index, sticks.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Shares the core's irq_req/irq_ret pair among N_SRC edge-triggered sources, one grant at a time.
// Latency: source edge to irq_req_o two cycles, bus read one cycle; backpressure: none, every access completes.
module riscv_irq_ctrl
    import riscv_irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic             irq_req_o,
    input  logic             irq_ret_i,
    output logic [N_SRC-1:0] src_ret_o
);

    irq_state_t       state;
    irq_state_t       state_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] prev;
    logic             ctrl_en;
    logic [3:0]       cur_id;

    logic             bus_wr;
    logic             bus_rd;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ret_clr;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] cur_onehot;
    logic             win_vld;
    logic [3:0]       win_id;
    logic             grant;
    logic             ret_fire;
    logic [31:0]      rd_mux;
    logic             unused;

    assign unused = ^write_data_i;

    assign bus_wr     = req_i & write_enable_i;
    assign bus_rd     = req_i & ~write_enable_i;
    assign rise       = irq_src_i & ~prev;
    assign w1c        = (bus_wr && addr_i == IRQ_PEND_OFF) ? write_data_i[N_SRC-1:0] : '0;
    assign cur_onehot = N_SRC'(1) << cur_id;
    assign ret_clr    = ret_fire ? cur_onehot : '0;
    assign cand       = pending & mask & {N_SRC{ctrl_en}};
    assign irq_req_o  = (state == ACTIVE);

    riscv_irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .vec   (cand),
        .valid (win_vld),
        .id    (win_id)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Once ACTIVE, nothing but the core's return moves the FSM: no preemption.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        ret_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (irq_ret_i) begin
                    ret_fire   = 1'b1;
                    state_next = RET;
                end
            end
            RET:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new rising edge is OR-ed in last so it survives a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev      <= '0;
            pending   <= '0;
            mask      <= '0;
            ctrl_en   <= 1'b0;
            cur_id    <= 4'd0;
            src_ret_o <= '0;
        end else begin
            prev      <= irq_src_i;
            pending   <= (pending & ~w1c & ~ret_clr) | rise;
            src_ret_o <= ret_clr;
            if (grant) begin
                cur_id <= win_id;
            end
            if (bus_wr && addr_i == IRQ_MASK_OFF) begin
                mask <= write_data_i[N_SRC-1:0];
            end
            if (bus_wr && addr_i == IRQ_CTRL_OFF) begin
                ctrl_en <= write_data_i[0];
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr_i)
            IRQ_MASK_OFF: rd_mux = 32'(mask);
            IRQ_PEND_OFF: rd_mux = 32'(pending);
            IRQ_CUR_OFF: begin
                if (state == ACTIVE) begin
                    rd_mux = {1'b1, 27'd0, cur_id};
                end
            end
            IRQ_CTRL_OFF: rd_mux = {31'd0, ctrl_en};
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_data_o <= 32'd0;
        end else if (bus_rd) begin
            read_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl: register access, grant timing, priority, masking and reset.
module tb_riscv_irq_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  irq_src;
    logic        irq_req;
    logic        irq_ret;
    logic [7:0]  src_ret;
    logic [31:0] rd;

    int checks   = 0;
    int failures = 0;

    riscv_irq_ctrl #(.N_SRC(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .write_enable_i (we),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .irq_src_i      (irq_src),
        .irq_req_o      (irq_req),
        .irq_ret_i      (irq_ret),
        .src_ret_o      (src_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [23:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        req = 1'b0;
        d = rdata;
    endtask

    task automatic ret_pulse();
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 24'd0; wdata = 32'd0;
        irq_src = 8'd0; irq_ret = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_src_ret", 32'(src_ret), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        bus_rd(24'h0, rd);  check("rst_mask", rd, 32'd0);
        bus_rd(24'h4, rd);  check("rst_pend", rd, 32'd0);
        bus_rd(24'h8, rd);  check("rst_cur", rd, 32'd0);
        bus_rd(24'hC, rd);  check("rst_ctrl", rd, 32'd0);
        bus_wr(24'h10, 32'hFFFF_FFFF);
        bus_rd(24'h10, rd); check("unmapped_rd", rd, 32'd0);

        // Single source, exact timing
        bus_wr(24'h0, 32'h01);
        bus_wr(24'hC, 32'h01);
        bus_rd(24'h0, rd);  check("mask_rb", rd, 32'h01);
        bus_rd(24'hC, rd);  check("ctrl_rb", rd, 32'h01);
        irq_src = 8'h01;
        tick();             check("s0_req_t1", 32'(irq_req), 32'd0);
        tick();             check("s0_req_t2", 32'(irq_req), 32'd1);
        bus_rd(24'h8, rd);  check("s0_cur", rd, 32'h8000_0000);
        ret_pulse();
        check("s0_src_ret", 32'(src_ret), 32'h01);
        check("s0_req_drop", 32'(irq_req), 32'd0);
        tick();             check("s0_src_ret_1cyc", 32'(src_ret), 32'd0);
        bus_rd(24'h4, rd);  check("s0_pend_clr", rd, 32'd0);
        check("s0_no_regrant", 32'(irq_req), 32'd0);
        irq_src = 8'h00;

        // Priority and no preemption
        bus_wr(24'h0, 32'hFF);
        irq_src = 8'h20;
        tick(); tick();     check("p5_req", 32'(irq_req), 32'd1);
        irq_src = 8'h24;
        tick(); tick();
        bus_rd(24'h8, rd);  check("p5_cur_held", rd, 32'h8000_0005);
        bus_rd(24'h4, rd);  check("p_pend_both", rd, 32'h24);
        ret_pulse();
        check("p5_src_ret", 32'(src_ret), 32'h20);
        check("p_req_r1", 32'(irq_req), 32'd0);
        tick();             check("p_req_r2", 32'(irq_req), 32'd0);
        tick();             check("p_req_r3", 32'(irq_req), 32'd1);
        bus_rd(24'h8, rd);  check("p2_cur", rd, 32'h8000_0002);
        ret_pulse();        check("p2_src_ret", 32'(src_ret), 32'h04);
        tick(); tick();     check("p_idle", 32'(irq_req), 32'd0);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        check("idle_ret_ignored", 32'(src_ret), 32'd0);
        irq_src = 8'h00;

        // Masking and global enable
        bus_wr(24'h0, 32'h00);
        irq_src = 8'h08;
        tick(); tick();     check("m_masked_req", 32'(irq_req), 32'd0);
        bus_rd(24'h4, rd);  check("m_pend", rd, 32'h08);
        bus_wr(24'h0, 32'h08);
        check("m_req_c1", 32'(irq_req), 32'd0);
        tick();             check("m_req_c2", 32'(irq_req), 32'd1);
        ret_pulse();        check("m_src_ret", 32'(src_ret), 32'h08);
        tick(); tick();
        bus_wr(24'hC, 32'h00);
        bus_wr(24'h0, 32'h00);
        irq_src = 8'h00; tick();
        irq_src = 8'h08; tick();
        bus_wr(24'h0, 32'h08);
        tick(); tick();     check("g_disabled_req", 32'(irq_req), 32'd0);
        bus_rd(24'h4, rd);  check("g_pend", rd, 32'h08);
        bus_wr(24'h4, 32'h08);
        bus_rd(24'h4, rd);  check("g_w1c", rd, 32'd0);
        bus_wr(24'hC, 32'h01);
        tick();             check("g_no_req", 32'(irq_req), 32'd0);
        irq_src = 8'h00;

        // Simultaneous set and W1C
        bus_wr(24'h0, 32'h00);
        req = 1'b1; we = 1'b1; addr = 24'h4; wdata = 32'h04; irq_src = 8'h04;
        tick();
        req = 1'b0; we = 1'b0;
        bus_rd(24'h4, rd);  check("sim_set_wins", rd, 32'h04);
        bus_wr(24'h4, 32'h04);
        bus_rd(24'h4, rd);  check("sim_w1c_later", rd, 32'd0);
        irq_src = 8'h00;

        // Reset mid-operation
        bus_wr(24'h0, 32'h10);
        irq_src = 8'h10;
        tick(); tick();     check("r_req", 32'(irq_req), 32'd1);
        bus_rd(24'h8, rd);  check("r_cur", rd, 32'h8000_0004);
        rst = 1'b1;
        #1;                 check("r_async_drop", 32'(irq_req), 32'd0);
        check("r_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;
        bus_rd(24'h0, rd);  check("r_mask", rd, 32'd0);
        bus_rd(24'hC, rd);  check("r_ctrl", rd, 32'd0);
        ret_pulse();
        check("r_no_src_ret", 32'(src_ret), 32'd0);
        check("r_no_req", 32'(irq_req), 32'd0);
        bus_rd(24'h4, rd);  check("r_pend_prev_clr", rd, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_irq_ctrl.md
# riscv_irq_ctrl

Interrupt controller that shares the core's single `irq_req`/`irq_ret` pair between up to `N_SRC` peripheral interrupt sources such as PS/2, UART and timer. It sits on the system bus as a memory-mapped device behind the top-level `addr[31:24]` device decode. It latches rising-edge events from the sources and grants one source at a time to the core under fixed priority. It routes the core's interrupt-return back to the granted peripheral only.

## Interface
- `N_SRC`, default 8: number of interrupt sources, legal 1..16. Source 0 has the highest priority.
- `clk_i`  in  1: system clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `req_i`  in  1: bus request, already decoded for this device.
- `write_enable_i`  in  1: 1 means write, 0 means read.
- `addr_i`  in  24: byte offset within the device.
- `write_data_i`  in  32: write data.
- `read_data_o`  out  32: registered read data. Reset value 0.
- `irq_src_i`  in  N_SRC: source interrupt levels, synchronous to `clk_i`.
- `irq_req_o`  out  1: interrupt request to the core. Reset value 0.
- `irq_ret_i`  in  1: one-cycle pulse from the core on `mret`.
- `src_ret_o`  out  N_SRC: one-hot, one-cycle interrupt-return to the granted source. Reset value 0.

## Operation
- Registers (offsets):
  - `0x00 MASK`: RW, bits [N_SRC-1:0]. Reset value 0, so all sources are masked.
  - `0x04 PENDING`: read returns the pending bits. A write clears each bit written as 1 (W1C).
  - `0x08 CURRENT`: RO. Bit 31 is the active flag; [3:0] is the granted id. Reads 0 when not active.
  - `0x0C CTRL`: RW. Bit 0 is the global enable. Reset value 0.
  - Any other offset reads 0. Writes to any other offset are ignored.
  - Unused upper bits read 0.
- Edge capture:
  - `prev` register holds the previous `irq_src_i`.
  - `rise = irq_src_i & ~prev` sets `pending`.
  - In the same cycle, a set wins over a W1C clear or a return-clear of the same bit.
- Candidates: `cand = pending & MASK`, qualified by `CTRL[0]`. The winner is the lowest-index set bit.
- FSM states: IDLE, ACTIVE, RET.
  - IDLE → ACTIVE when `cand != 0` and global enable is set. The winner id is latched into `cur_id`.
  - ACTIVE: `irq_req_o` = 1. No preemption. Changes to MASK or CTRL, or a higher-priority pending bit, do not alter `cur_id`.
  - ACTIVE → RET on `irq_ret_i`. On that edge: `src_ret_o[cur_id]` pulses, `pending[cur_id]` clears, and `irq_req_o` goes to 0.
  - RET → IDLE unconditionally after one cycle.
  - `irq_ret_i` in IDLE or RET is ignored. No `src_ret_o` is produced.
- A W1C of `pending[cur_id]` while ACTIVE clears the bit but does not end ACTIVE. The return still pulses `src_ret_o[cur_id]`.
- Reset, including mid-operation, clears MASK, PENDING, CTRL, `prev`, `cur_id` and all outputs, and puts the FSM in IDLE.

## Timing
- Source edge sampled at edge t:
  - The pending bit is visible from t+1.
  - `irq_req_o` goes high at t+2 at the earliest: one cycle of arbitration, then the registered FSM and output.
- `irq_ret_i` high in cycle r:
  - `src_ret_o` is high and `irq_req_o` is low during r+1.
  - RET occupies r+1, IDLE occupies r+2.
  - The next `irq_req_o` can rise no earlier than r+3, so the request is low for at least 2 cycles between grants.
- Bus read accepted in cycle c (`req_i` & `!write_enable_i`): `read_data_o` is valid in c+1 and holds until the next read. This is the same one-cycle latency as data memory.
- Bus write accepted in cycle c takes effect from c+1. A read in the same cycle returns the pre-write value.
- `req_i` low: registers and `read_data_o` are unchanged. No stall output; every access completes in one cycle.

## Structure
- Package `riscv_irq_pkg` holds:
  - register offset localparams (`IRQ_MASK_OFF`, `IRQ_PEND_OFF`, `IRQ_CUR_OFF`, `IRQ_CTRL_OFF`);
  - FSM enum `irq_state_t` {IDLE, ACTIVE, RET};
  - `MAX_SRC = 16`.
- Sub-module `riscv_irq_prio_enc`: combinational, parameterised by N_SRC. Inputs the vector; outputs `valid` and a 4-bit id of the lowest set bit.

## Test plan
- Reset state: after reset, read every register → all read 0; `irq_req_o` = 0; `src_ret_o` = 0.
- Single source, exact timing:
  - Stimulus: MASK=0x01, CTRL=1, rise on `irq_src_i[0]` at edge t.
  - `irq_req_o` = 1 at t+2; CURRENT reads 0x8000_0000.
  - `irq_ret_i` pulse → `src_ret_o` = 0x01 for one cycle; PENDING reads 0.
- Priority and no preemption:
  - Stimulus: MASK=0xFF, CTRL=1. Rise on src 5, grant taken; then rise on src 2.
  - CURRENT id stays 5 until return.
  - After return, src 2 is granted with `irq_req_o` rising at r+3.
- Masking and global enable:
  - Rise on src 3 with MASK=0 → PENDING=0x08, no request.
  - Write MASK=0x08 → request follows 2 cycles later.
  - Repeat with CTRL=0 → no request.
- Simultaneous set/clear: write PENDING W1C=0x04 in the same cycle as a rise on src 2 → PENDING bit 2 remains 1.
- Reset mid-operation: assert `rst_i` while ACTIVE with id 4 → `irq_req_o` drops immediately (asynchronously); MASK=0; a later `irq_ret_i` produces no `src_ret_o`.
